// File: rtl/converter_bits_recv.sv
// converter_bits_recv
//   Serial-to-parallel receive stage. It takes the MSB-first bit stream from the
//   transmit serializer and hunts for COM_SYMBOL to find byte alignment. After
//   COM_COUNT consecutive aligned COMs it declares the lane active. From then on
//   it presents each recovered byte, with a one-cycle valid pulse for non-COM bytes.
// Ports
//   dclk            in   1  bit clock, one serial bit per rising edge
//   default_values  in   1  synchronous active-high reset
//   data_in         in   1  serial data bit, MSB first
//   data_out        out  8  last recovered byte (registered)
//   valid_out       out  1  pulse: data_out holds a new non-COM byte
//   active          out  1  lane aligned and locked (level, sticky until reset)
module converter_bits_recv #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned COM_COUNT  = 4
) (
  input  logic       dclk,
  input  logic       default_values,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKING = 2'd1,
    ST_ALIGNED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  // Only the seven most recent bits are kept; the eighth bit of a window is data_in itself.
  logic [BYTE_W-2:0]   r_sr;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [CNT_W-1:0]    r_com_cnt;
  logic [CNT_W-1:0]    r_fill_cnt;
  logic [BYTE_W-1:0]   r_data_out;
  logic                r_valid;
  logic                r_active;

  logic [BYTE_W-1:0]   w_nxt;
  logic                w_filled;
  logic                w_boundary;
  logic                w_is_com;
  logic                w_lock_done;
  logic [BIT_W-1:0]    w_bit_cnt_nxt;
  logic [CNT_W-1:0]    w_com_cnt_nxt;
  logic [CNT_W-1:0]    w_fill_cnt_nxt;
  logic [BYTE_W-1:0]   w_data_nxt;
  logic                w_valid_nxt;
  logic                w_active_nxt;

  // The window is checked only once it holds 8 real bits, so reset-zero contents never match.
  assign w_nxt       = {r_sr, data_in};
  assign w_filled    = (r_fill_cnt >= CNT_W'(7));
  assign w_boundary  = (r_bit_cnt == BIT_W'(7));
  assign w_is_com    = (w_nxt == COM_SYMBOL);
  assign w_lock_done = ((r_com_cnt + CNT_W'(1)) == CNT_W'(COM_COUNT));

  // State register
  always_ff @(posedge dclk) begin
    if (default_values) r_state <= ST_SEARCH;
    else                r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SEARCH: begin
        if (w_filled && w_is_com)
          w_state_nxt = (COM_COUNT == 1) ? ST_ALIGNED : ST_LOCKING;
      end
      ST_LOCKING: begin
        if (w_boundary) begin
          if (!w_is_com)        w_state_nxt = ST_SEARCH;
          else if (w_lock_done) w_state_nxt = ST_ALIGNED;
        end
      end
      ST_ALIGNED: w_state_nxt = ST_ALIGNED;
      default:    w_state_nxt = ST_SEARCH;
    endcase
  end

  // Output/datapath next values
  always_comb begin
    w_bit_cnt_nxt  = r_bit_cnt + BIT_W'(1);
    w_com_cnt_nxt  = r_com_cnt;
    w_fill_cnt_nxt = (r_fill_cnt == CNT_W'(8)) ? r_fill_cnt : r_fill_cnt + CNT_W'(1);
    w_data_nxt     = r_data_out;
    w_valid_nxt    = 1'b0;
    w_active_nxt   = r_active;
    case (r_state)
      ST_SEARCH: begin
        w_bit_cnt_nxt = BIT_W'(0);
        if (w_filled && w_is_com) begin
          w_com_cnt_nxt = CNT_W'(1);
          if (COM_COUNT == 1) w_active_nxt = 1'b1;
        end
      end
      ST_LOCKING: begin
        if (w_boundary) begin
          if (w_is_com) begin
            w_com_cnt_nxt = r_com_cnt + CNT_W'(1);
            if (w_lock_done) w_active_nxt = 1'b1;
          end else begin
            w_com_cnt_nxt = CNT_W'(0);
          end
        end
      end
      ST_ALIGNED: begin
        // COM bytes still refresh data_out but never pulse valid
        if (w_boundary) begin
          w_data_nxt  = w_nxt;
          w_valid_nxt = !w_is_com;
        end
      end
      default: begin
        w_bit_cnt_nxt = BIT_W'(0);
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge dclk) begin
    if (default_values) begin
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_com_cnt  <= '0;
      r_fill_cnt <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_sr       <= w_nxt[BYTE_W-2:0];
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_com_cnt  <= w_com_cnt_nxt;
      r_fill_cnt <= w_fill_cnt_nxt;
      r_data_out <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_active   <= w_active_nxt;
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid;
  assign active    = r_active;

endmodule
